// File: rtl/std_reg_arb_pkg.sv
// std_reg_arb_pkg: shared FSM state type and index-width helper for the std_reg arbiter
package std_reg_arb_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} arb_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/std_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker scanning last+1, last+2, ... mod N
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);
    assign o_valid = |i_req;
    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_last) + 1 + k) % N;
            if (i_req[j]) o_idx = IW'(j);
        end
    end
endmodule

// File: rtl/std_reg_arbiter.sv
// std_reg_arbiter: round-robin go/done arbiter sharing one std_reg among N requesters
module std_reg_arbiter
    import std_reg_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req_go,
    input  logic [N*WIDTH-1:0]     req_data,
    output logic [N-1:0]           req_done,
    output logic [WIDTH-1:0]       reg_in,
    output logic                   reg_write_en,
    input  logic                   reg_done,
    input  logic [WIDTH-1:0]       reg_out,
    output logic [WIDTH-1:0]       rd_data,
    output logic [idx_w(N)-1:0]    grant_id,
    output logic                   busy,
    output logic                   err
);
    localparam int IW = idx_w(N);
    localparam int CW = $clog2(TIMEOUT);
    arb_state_t       r_state, w_next;
    logic [IW-1:0]    r_last, r_grant, w_pick;
    logic             r_mask_valid, r_err, w_valid, w_timeout;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data, w_sel;
    logic [N-1:0]     w_elig;
    // The just-served requester is masked for one IDLE cycle so a late go drop is not re-granted.
    assign w_elig    = req_go & ~(N'(r_mask_valid) << r_last);
    assign w_timeout = r_cnt == CW'(TIMEOUT - 2);
    rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req   (w_elig),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick == IW'(i)) w_sel = req_data[i*WIDTH +: WIDTH];
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_valid ? WRITE : IDLE;
            WRITE:   w_next = WAIT;
            WAIT:    w_next = (reg_done || w_timeout) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= IW'(N - 1);
            r_grant      <= '0;
            r_mask_valid <= 1'b0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_mask_valid <= 1'b0;
                    if (w_valid) begin
                        r_grant <= w_pick;
                        r_data  <= w_sel;
                    end
                end
                WRITE: r_cnt <= '0;
                WAIT: begin
                    if (!reg_done) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                DONE: begin
                    r_last       <= r_grant;
                    r_mask_valid <= 1'b1;
                end
            endcase
        end
    end
    assign req_done     = (r_state == DONE) ? (N'(1) << r_grant) : '0;
    assign reg_write_en = r_state == WRITE;
    assign reg_in       = r_data;
    assign rd_data      = reg_out;
    assign grant_id     = r_grant;
    assign busy         = r_state != IDLE;
    assign err          = r_err;
endmodule

// File: tb/tb_std_reg_arbiter.sv
// tb_std_reg_arbiter: directed checks of the arbiter against a behavioural std_reg
module tb_std_reg_arbiter;
    localparam int N = 4, W = 3, TO = 8;
    logic           clk = 1'b0, reset = 1'b1, tie_low = 1'b0;
    logic [N-1:0]   req_go = '0, req_done;
    logic [N*W-1:0] req_data = '0;
    logic [W-1:0]   reg_in, reg_out, rd_data;
    logic           reg_write_en, reg_done, m_done, busy, err;
    logic [1:0]     grant_id;
    int             n_cmp = 0, n_bad = 0;

    std_reg_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_go(req_go), .req_data(req_data),
        .req_done(req_done), .reg_in(reg_in), .reg_write_en(reg_write_en),
        .reg_done(reg_done), .reg_out(reg_out), .rd_data(rd_data),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // std_reg: latch on write_en, done one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_out <= '0;
            m_done  <= 1'b0;
        end else begin
            m_done <= reg_write_en;
            if (reg_write_en) reg_out <= reg_in;
        end
    end
    assign reg_done = m_done & ~tie_low;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int max, output int cyc, output logic [N-1:0] d);
        cyc = 0;
        d   = '0;
        while (cyc < max && d == '0) begin
            tick();
            cyc++;
            d = req_done;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        req_go = 4'b1111;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (req_done !== 4'b0000 || reg_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_outs done=%b we=%b exp=0000/0", req_done, reg_write_en); end
        n_cmp++; if (reg_in !== 3'd0 || err !== 1'b0 || grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_regs in=%0d err=%b gid=%0d exp=0/0/0", reg_in, err, grant_id); end
        req_go = '0;
        reset  = 1'b0;
    endtask

    task automatic test_single;
        logic [N-1:0] d;
        req_data[2*W +: W] = 3'b101;
        req_go = 4'b0100;
        tick();
        n_cmp++; if (reg_write_en !== 1'b1 || reg_in !== 3'd5) begin n_bad++; $display("FAIL single_write we=%b in=%0d exp=1/5", reg_write_en, reg_in); end
        n_cmp++; if (grant_id !== 2'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL single_grant gid=%0d busy=%b exp=2/1", grant_id, busy); end
        tick();
        n_cmp++; if (reg_write_en !== 1'b0 || req_done !== 4'b0000) begin n_bad++; $display("FAIL single_wait we=%b done=%b exp=0/0000", reg_write_en, req_done); end
        tick();
        d = req_done;
        n_cmp++; if (d !== 4'b0100 || rd_data !== 3'd5 || grant_id !== 2'd2) begin n_bad++; $display("FAIL single_done done=%b rd=%0d gid=%0d exp=0100/5/2", d, rd_data, grant_id); end
        req_go = '0;
        tick();
        n_cmp++; if (req_done !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL single_after done=%b busy=%b exp=0000/0", req_done, busy); end
    endtask

    task automatic test_contention;
        int cyc;
        logic [N-1:0] d;
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        req_data = {3'd4, 3'd3, 3'd2, 3'd1};
        req_go   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_until_done(12, cyc, d);
            n_cmp++; if (d !== (4'b0001 << (k % 4)) || grant_id !== 2'(k % 4)) begin n_bad++; $display("FAIL contend_order k=%0d done=%b gid=%0d exp_gid=%0d", k, d, grant_id, k % 4); end
            n_cmp++; if (rd_data !== 3'(k % 4 + 1)) begin n_bad++; $display("FAIL contend_data k=%0d rd=%0d exp=%0d", k, rd_data, k % 4 + 1); end
            n_cmp++; if (cyc !== ((k == 0) ? 3 : 4)) begin n_bad++; $display("FAIL contend_gap k=%0d cycles=%0d exp=%0d", k, cyc, (k == 0) ? 3 : 4); end
        end
        req_go = '0;
        tick();
        tick();
    endtask

    task automatic test_mask;
        int cyc;
        logic [N-1:0] d;
        int exp_g [4] = '{1, 3, 1, 3};
        req_go = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            run_until_done(12, cyc, d);
            n_cmp++; if (grant_id !== 2'(exp_g[k]) || d !== (4'b0001 << exp_g[k])) begin n_bad++; $display("FAIL mask_alt k=%0d gid=%0d done=%b exp_gid=%0d", k, grant_id, d, exp_g[k]); end
        end
        req_go = 4'b0010;
        run_until_done(12, cyc, d);
        n_cmp++; if (d !== 4'b0010) begin n_bad++; $display("FAIL mask_solo1 done=%b exp=0010", d); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mask_hold1 busy=%b exp=0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mask_hold2 busy=%b exp=0", busy); end
        tick();
        n_cmp++; if (reg_write_en !== 1'b1 || grant_id !== 2'd1) begin n_bad++; $display("FAIL mask_regrant we=%b gid=%0d exp=1/1", reg_write_en, grant_id); end
        req_go = '0;
        run_until_done(6, cyc, d);
        n_cmp++; if (d !== 4'b0010 || cyc !== 2) begin n_bad++; $display("FAIL mask_solo2 done=%b cycles=%0d exp=0010/2", d, cyc); end
        tick();
    endtask

    task automatic test_latch;
        int cyc;
        logic [N-1:0] d;
        req_data[0 +: W] = 3'd3;
        req_go = 4'b0001;
        tick();
        req_data[0 +: W] = 3'd6;
        req_go = '0;
        run_until_done(6, cyc, d);
        n_cmp++; if (d !== 4'b0001 || rd_data !== 3'd3) begin n_bad++; $display("FAIL latch done=%b rd=%0d exp=0001/3", d, rd_data); end
        tick();
    endtask

    task automatic test_timeout;
        int cyc;
        logic [N-1:0] d;
        tie_low = 1'b1;
        req_data[2*W +: W] = 3'd5;
        req_go = 4'b0100;
        tick();
        n_cmp++; if (reg_write_en !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL to_write we=%b err=%b exp=1/0", reg_write_en, err); end
        run_until_done(20, cyc, d);
        n_cmp++; if (d !== 4'b0100 || cyc !== TO) begin n_bad++; $display("FAIL to_done done=%b cycles=%0d exp=0100/%0d", d, cyc, TO); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err err=%b exp=1", err); end
        req_go  = '0;
        tie_low = 1'b0;
        tick();
        req_data[3*W +: W] = 3'd7;
        req_go = 4'b1000;
        run_until_done(12, cyc, d);
        n_cmp++; if (d !== 4'b1000 || rd_data !== 3'd7 || cyc !== 3) begin n_bad++; $display("FAIL to_next done=%b rd=%0d cycles=%0d exp=1000/7/3", d, rd_data, cyc); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_sticky err=%b exp=1", err); end
        req_go = '0;
        tick();
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [N-1:0] d;
        tie_low = 1'b1;
        req_go  = 4'b0001;
        tick();
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1 || reg_write_en !== 1'b0) begin n_bad++; $display("FAIL mid_inwait busy=%b we=%b exp=1/0", busy, reg_write_en); end
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        tie_low = 1'b0;
        n_cmp++; if (busy !== 1'b0 || req_done !== 4'b0000 || reg_write_en !== 1'b0) begin n_bad++; $display("FAIL mid_state busy=%b done=%b we=%b exp=0/0000/0", busy, req_done, reg_write_en); end
        n_cmp++; if (err !== 1'b0 || reg_in !== 3'd0 || grant_id !== 2'd0) begin n_bad++; $display("FAIL mid_regs err=%b in=%0d gid=%0d exp=0/0/0", err, reg_in, grant_id); end
        req_go = 4'b1010;
        run_until_done(12, cyc, d);
        n_cmp++; if (d !== 4'b0010 || grant_id !== 2'd1) begin n_bad++; $display("FAIL mid_first done=%b gid=%0d exp=0010/1", d, grant_id); end
        req_go = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_mask();
        test_latch();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
